// File: rtl/md_pkg.sv
// md_pkg: shared op/state encodings, iteration count and sign helper for md_unit
package md_pkg;
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;
  localparam logic [2:0] MD_IDLE = 3'd0;
  localparam logic [2:0] MD_PREP = 3'd1;
  localparam logic [2:0] MD_ITER = 3'd2;
  localparam logic [2:0] MD_FIX  = 3'd3;
  localparam logic [2:0] MD_DONE = 3'd4;
  localparam int MD_ITERS = 32;
  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/md_if.sv
// md_if: md_unit request/response bundle; master drives start/op/a/b/flush, slave drives busy/done/result
interface md_if;
  logic        start;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  modport master(output start, flush, op, a, b, input busy, done, result);
  modport slave(input start, flush, op, a, b, output busy, done, result);
endinterface

// File: rtl/md_shift_core.sv
// md_shift_core: 64-bit acc {hi,lo}; load puts init in lo, step does shift-add (mul) or restoring shift-subtract (div, hi=rem lo=quot); MD_FAST_MUL_EN drops the mul step
module md_shift_core (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic        div,
  input  logic [31:0] init,
  input  logic [31:0] opnd,
  output logic [63:0] acc
);
  logic [32:0] rem_sh, diff;
  logic [63:0] nxt_d, nxt_m;
`ifndef MD_FAST_MUL_EN
  logic [32:0] sum;
`endif
  always_comb begin
    rem_sh = acc[63:31];
    diff = rem_sh - {1'b0, opnd};
    nxt_d = {diff[32] ? rem_sh[31:0] : diff[31:0], acc[30:0], ~diff[32]};
`ifdef MD_FAST_MUL_EN
    nxt_m = acc;
`else
    sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    nxt_m = {sum, acc[31:1]};
`endif
  end
  always_ff @(posedge clk) begin
    if (load) acc <= {32'd0, init};
    else if (step) acc <= div ? nxt_d : nxt_m;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: RV32M mul/div sequencer; ports clk, rst, bus (md_if.slave: start/op/a/b/flush in, busy/done/result out); MD_FAST_MUL_EN makes multiplies single-step in PREP
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst,
  md_if.slave bus
);
  logic [2:0]      state, nxt, op_q;
  logic [XLEN-1:0] a_q, b_q, ma, mb, spec_res, res_fix, pre_res, result_q;
  logic [4:0]      cnt;
  logic [63:0]     acc, prod;
  logic            a_neg, b_neg, is_div, special, fast_mul;
  always_comb begin
    is_div = op_q[2];
    a_neg = a_q[31] & (op_q == MD_MULH || op_q == MD_MULHSU || op_q == MD_DIV || op_q == MD_REM);
    b_neg = b_q[31] & (op_q == MD_MULH || op_q == MD_DIV || op_q == MD_REM);
    ma = neg_if(a_neg, a_q);
    mb = neg_if(b_neg, b_q);
    special = is_div & (b_q == '0 || (!op_q[0] && a_q == 32'h8000_0000 && b_q == '1));
    spec_res = b_q == '0 ? (op_q[1] ? a_q : '1) : (op_q[1] ? '0 : 32'h8000_0000);
    prod = (a_neg ^ b_neg) ? -acc : acc;
    res_fix = is_div ? (op_q[1] ? neg_if(a_neg, acc[63:32]) : neg_if(a_neg ^ b_neg, acc[31:0]))
                     : (op_q == MD_MUL ? prod[31:0] : prod[63:32]);
  end
`ifdef MD_FAST_MUL_EN
  logic signed [32:0] sa, sb;
  logic signed [63:0] fprod;
  always_comb begin
    sa = {a_neg, a_q};
    sb = {b_neg, b_q};
    fprod = 64'(sa) * 64'(sb);
    fast_mul = !is_div;
    pre_res = special ? spec_res : (op_q == MD_MUL ? fprod[31:0] : fprod[63:32]);
  end
`else
  assign fast_mul = 1'b0;
  assign pre_res = spec_res;
`endif
  always_comb begin
    nxt = state;
    case (state)
      MD_IDLE: nxt = bus.start ? MD_PREP : MD_IDLE;
      MD_PREP: nxt = (special || fast_mul) ? MD_DONE : MD_ITER;
      MD_ITER: nxt = cnt == 5'(MD_ITERS - 1) ? MD_FIX : MD_ITER;
      MD_FIX:  nxt = MD_DONE;
      MD_DONE: nxt = bus.start ? MD_PREP : MD_IDLE;
      default: nxt = MD_IDLE;
    endcase
    if (bus.flush) nxt = MD_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt <= '0;
      result_q <= '0;
    end else begin
      state <= nxt;
      cnt <= state == MD_ITER ? cnt + 5'd1 : '0;
      if (nxt == MD_PREP) begin
        op_q <= bus.op;
        a_q <= bus.a;
        b_q <= bus.b;
      end
      if (nxt == MD_DONE) result_q <= state == MD_PREP ? pre_res : res_fix;
    end
  end
  md_shift_core core (
    .clk(clk),
    .load(state == MD_PREP),
    .step(state == MD_ITER),
    .div(is_div),
    .init(ma),
    .opnd(mb),
    .acc(acc)
  );
  assign bus.busy = state == MD_PREP || state == MD_ITER || state == MD_FIX;
  assign bus.done = state == MD_DONE;
  assign bus.result = result_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table vectors, hand sequences and random ops against an arithmetic reference model
module tb_md_unit;
  import md_pkg::*;
`ifdef MD_FAST_MUL_EN
  localparam int ML = 2;
`else
  localparam int ML = 35;
`endif
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[12];
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_exp;
  always #5 clk = ~clk;
  md_if bus();
  md_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p = '0;
    case (op)
      MD_MUL:    begin p = ua * ub; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      MD_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      MD_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return ML;
    if (b == 0) return 2;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int cyc;
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    check($sformatf("%s_busy_c1", nm), 32'(bus.busy), 32'd1);
    while (!bus.done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (lat > 6 && cyc == 5) begin
        bus.start = 1'b1;
        bus.op = ~op;
        bus.a = ~a;
      end
      if (cyc == 6) bus.start = 1'b0;
    end
    check($sformatf("%s_lat", nm), 32'(cyc), 32'(lat));
    check($sformatf("%s_res", nm), bus.result, exp);
    check($sformatf("%s_busy_done", nm), 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check($sformatf("%s_pulse", nm), 32'(bus.done), 32'd0);
    check($sformatf("%s_hold", nm), bus.result, exp);
    last_exp = exp;
  endtask

  initial begin
    int cyc, c2;
    logic saw;
    logic [2:0] op;
    logic [31:0] a, b;
    vecs[0]  = '{MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35};
    vecs[1]  = '{MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35};
    vecs[2]  = '{MD_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 2};
    vecs[3]  = '{MD_REMU,   32'd100,       32'd0,         32'h0000_0064, 2};
    vecs[4]  = '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[5]  = '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2};
    vecs[6]  = '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML};
    vecs[7]  = '{MD_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, ML};
    vecs[8]  = '{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML};
    vecs[9]  = '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML};
    vecs[10] = '{MD_DIVU,   32'd1000,      32'd7,         32'd142,       35};
    vecs[11] = '{MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 2};
    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op = MD_DIVU;
    bus.a = 32'd1000;
    bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_prio_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("flush_prio_busy2", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    saw = 1'b0;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) saw = 1'b1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy_c11", 32'(bus.busy), 32'd0);
    check("flush_done_c11", 32'(bus.done), 32'd0);
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) saw = 1'b1;
    end
    check("flush_no_done", 32'(saw), 32'd0);
    check("flush_result_held", bus.result, last_exp);
    run_op("after_flush", MD_DIVU, 32'd1000, 32'd7, 32'd142, 35);
    bus.start = 1'b1;
    bus.op = MD_MUL;
    bus.a = 32'd3;
    bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_first_lat", 32'(cyc), 32'(ML));
    check("b2b_first_res", bus.result, 32'd15);
    bus.start = 1'b1;
    bus.a = 32'd6;
    bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c2 = 1;
    check("b2b_no_gap", 32'(bus.busy), 32'd1);
    while (!bus.done && c2 < 60) begin
      @(posedge clk); #1;
      c2++;
    end
    check("b2b_apart", 32'(c2), 32'(ML));
    check("b2b_second_res", bus.result, 32'd42);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op = MD_DIV;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    run_op("after_rst", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_md(op, a, b), lat_of(op, a, b));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
